// File: rtl/vga_pattern_gen.sv
// VGA timing generator with eleven selectable test patterns.
// Mode steps come from a debounced button or a frame-count auto-advance.
module vga_pattern_gen #(
   parameter int H_ACTIVE    = 1024,
   parameter int H_FP        = 24,
   parameter int H_SYNC      = 136,
   parameter int H_BP        = 160,
   parameter int V_ACTIVE    = 768,
   parameter int V_FP        = 3,
   parameter int V_SYNC      = 6,
   parameter int V_BP        = 29,
   parameter bit HS_POL      = 1'b0,
   parameter bit VS_POL      = 1'b0,
   parameter int COLOR_W     = 6,
   parameter int DEBOUNCE    = 90000,
   parameter int AUTO_FRAMES = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               key_n,
   output logic               hs,
   output logic               vs,
   output logic               de,
   output logic [11:0]        x,
   output logic [11:0]        y,
   output logic [COLOR_W-1:0] r,
   output logic [COLOR_W-1:0] g,
   output logic [COLOR_W-1:0] b,
   output logic [3:0]         mode,
   output logic               frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
   localparam logic [11:0] X_LAST = 12'(H_ACTIVE - 1);
   localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

   localparam int DB_W = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE);
   localparam logic [DB_W-1:0] DB_PRE = DB_W'(DEBOUNCE - 1);

   localparam bit AUTO_EN = AUTO_FRAMES > 0;
   localparam int AF_W    = AUTO_EN ? $clog2(AUTO_FRAMES + 1) : 1;
   localparam logic [AF_W-1:0] AF_LAST =
      AF_W'(AUTO_EN ? AUTO_FRAMES - 1 : 0);

   localparam logic [COLOR_W-1:0] MAX = '1;

   typedef enum logic [3:0] {
      M_BLACK  = 4'd0,
      M_WHITE  = 4'd1,
      M_RED    = 4'd2,
      M_GREEN  = 4'd3,
      M_BLUE   = 4'd4,
      M_GRID_S = 4'd5,
      M_GRID_L = 4'd6,
      M_RAMP_H = 4'd7,
      M_RAMP_V = 4'd8,
      M_BARS   = 4'd9,
      M_SCROLL = 4'd10
   } mode_t;

   logic [11:0]     h_cnt;
   logic [11:0]     v_cnt;
   logic [11:0]     scroll;
   logic [DB_W-1:0] db_cnt;
   logic [AF_W-1:0] af_cnt;
   logic            pending;
   mode_t           mode_q;
   mode_t           mode_nx;

   logic h_last;
   logic v_last;
   logic frame_end;
   logic btn_req;
   logic auto_req;
   logic step_req;

   assign h_last    = (h_cnt == H_LAST);
   assign v_last    = (v_cnt == V_LAST);
   assign frame_end = h_last & v_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= v_last ? '0 : v_cnt + 12'd1;
      end else begin
         h_cnt <= h_cnt + 12'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         scroll <= '0;
      else if (frame_end)
         scroll <= (scroll == X_LAST) ? '0 : scroll + 12'd1;
   end

   // Request fires on the single cycle the low-run reaches DEBOUNCE.
   assign btn_req = !key_n && (db_cnt == DB_PRE);

   always_ff @(posedge clk) begin
      if (rst || key_n)
         db_cnt <= '0;
      else if (db_cnt != DB_MAX)
         db_cnt <= db_cnt + 1'b1;
   end

   assign auto_req = AUTO_EN && frame_end && (af_cnt == AF_LAST);

   always_ff @(posedge clk) begin
      if (rst || !AUTO_EN)
         af_cnt <= '0;
      else if (frame_end)
         af_cnt <= (af_cnt == AF_LAST) ? '0 : af_cnt + 1'b1;
   end

   assign step_req = btn_req | auto_req;

   always_comb begin
      mode_nx = mode_t'(mode_q + 4'd1);
      if (mode_q == M_SCROLL)
         mode_nx = M_BLACK;
   end

   // Requests collapse into one flag; the mode only moves between frames.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= 1'b0;
         mode_q  <= M_BLACK;
      end else if (frame_end) begin
         if (pending || step_req)
            mode_q <= mode_nx;
         pending <= 1'b0;
      end else if (step_req) begin
         pending <= 1'b1;
      end
   end

   logic               de_c;
   logic               hs_c;
   logic               vs_c;
   logic [15:0]        h8;
   logic [2:0]         bar;
   logic [COLOR_W-1:0] ramp_h;
   logic [COLOR_W-1:0] ramp_v;
   logic [COLOR_W-1:0] r_c;
   logic [COLOR_W-1:0] g_c;
   logic [COLOR_W-1:0] b_c;

   assign de_c = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs_c = (h_cnt >= HS_BEG && h_cnt <= HS_END) ? HS_POL : !HS_POL;
   assign vs_c = (v_cnt >= VS_BEG && v_cnt <= VS_END) ? VS_POL : !VS_POL;

   assign ramp_h = COLOR_W'(h_cnt >> 2);
   assign ramp_v = COLOR_W'(v_cnt >> 2);

   // Bar index floor(8x/H_ACTIVE) via threshold compares, no divider.
   assign h8 = {1'b0, h_cnt, 3'b000};

   always_comb begin
      bar = '0;
      for (int k = 1; k < 8; k++)
         if (h8 >= 16'(k * H_ACTIVE))
            bar = 3'(k);
   end

   always_comb begin
      r_c = '0;
      g_c = '0;
      b_c = '0;
      unique case (mode_q)
         M_BLACK: ;
         M_WHITE: begin
            r_c = MAX;
            g_c = MAX;
            b_c = MAX;
         end
         M_RED:   r_c = MAX;
         M_GREEN: g_c = MAX;
         M_BLUE:  b_c = MAX;
         M_GRID_S:
            if (!(h_cnt[4] ^ v_cnt[4])) begin
               r_c = MAX;
               g_c = MAX;
               b_c = MAX;
            end
         M_GRID_L:
            if (!(h_cnt[6] ^ v_cnt[6])) begin
               r_c = MAX;
               g_c = MAX;
               b_c = MAX;
            end
         M_RAMP_H: begin
            r_c = ramp_h;
            g_c = ramp_h;
            b_c = ramp_h;
         end
         M_RAMP_V: begin
            r_c = ramp_v;
            g_c = ramp_v;
            b_c = ramp_v;
         end
         M_BARS:
            unique case (bar)
               3'd0: r_c = MAX;
               3'd1: g_c = MAX;
               3'd2: b_c = MAX;
               3'd3: begin
                  r_c = MAX;
                  b_c = MAX;
               end
               3'd4: begin
                  r_c = MAX;
                  g_c = MAX;
               end
               3'd5: begin
                  g_c = MAX;
                  b_c = MAX;
               end
               3'd6: begin
                  r_c = MAX;
                  g_c = MAX;
                  b_c = MAX;
               end
               default: ;
            endcase
         M_SCROLL:
            if (h_cnt == scroll) begin
               r_c = MAX;
               g_c = MAX;
               b_c = MAX;
            end
         default: begin
            r_c = MAX;
            g_c = MAX;
            b_c = MAX;
         end
      endcase
      if (!de_c) begin
         r_c = '0;
         g_c = '0;
         b_c = '0;
      end
   end

   // mode is re-registered so it changes together with frame_start.
   always_ff @(posedge clk) begin
      if (rst) begin
         hs          <= !HS_POL;
         vs          <= !VS_POL;
         de          <= 1'b0;
         x           <= '0;
         y           <= '0;
         r           <= '0;
         g           <= '0;
         b           <= '0;
         mode        <= '0;
         frame_start <= 1'b0;
      end else begin
         hs          <= hs_c;
         vs          <= vs_c;
         de          <= de_c;
         x           <= de_c ? h_cnt : '0;
         y           <= de_c ? v_cnt : '0;
         r           <= r_c;
         g           <= g_c;
         b           <= b_c;
         mode        <= mode_q;
         frame_start <= (h_cnt == '0) && (v_cnt == '0);
      end
   end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen on a shrunken raster.
// A frame-arithmetic reference model checks every output each cycle.
module tb_vga_pattern_gen;

   localparam int HA = 32;
   localparam int HF = 2;
   localparam int HSY = 4;
   localparam int HB = 6;
   localparam int VA = 8;
   localparam int VF = 1;
   localparam int VSY = 2;
   localparam int VB = 2;
   localparam int HT = HA + HF + HSY + HB;
   localparam int VT = VA + VF + VSY + VB;
   localparam int FRAME = HT * VT;
   localparam int CW = 6;
   localparam int DB = 20;
   localparam int AF = 3;
   localparam int MX = 63;
   localparam int NT = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          key_n = 1'b1;
   logic          hs;
   logic          vs;
   logic          de;
   logic [11:0]   x;
   logic [11:0]   y;
   logic [CW-1:0] r;
   logic [CW-1:0] g;
   logic [CW-1:0] b;
   logic [3:0]    mode;
   logic          frame_start;

   vga_pattern_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
      .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(CW),
      .DEBOUNCE(DB), .AUTO_FRAMES(AF)
   ) dut (
      .clk(clk), .rst(rst), .key_n(key_n),
      .hs(hs), .vs(vs), .de(de), .x(x), .y(y),
      .r(r), .g(g), .b(b), .mode(mode),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          hs;
      logic          vs;
      logic          de;
      logic [11:0]   x;
      logic [11:0]   y;
      logic [CW-1:0] r;
      logic [CW-1:0] g;
      logic [CW-1:0] b;
      logic [3:0]    m;
      logic          fs;
   } px_t;

   typedef struct {
      int md;
      int px;
      int py;
      int er;
      int eg;
      int eb;
   } vec_t;

   vec_t tbl[NT];
   int   hit[NT];

   int checks = 0;
   int errors = 0;
   int t = 0;
   int mode_m = 0;
   int fends = 0;
   int low_m = 0;
   bit pend = 1'b0;
   int burst = 0;

   // Expected pixel straight from the raster and pattern rules.
   function automatic px_t pix(int h, int v, int md, int sc);
      px_t p;
      int c;
      int idx;
      int bars[8];
      int cr;
      int cg;
      int cb;
      bars = '{4, 2, 1, 5, 6, 3, 7, 0};
      p = '0;
      p.de = (h < HA) && (v < VA);
      p.hs = (h >= HA + HF && h < HA + HF + HSY) ? 1'b0 : 1'b1;
      p.vs = (v >= VA + VF && v < VA + VF + VSY) ? 1'b0 : 1'b1;
      p.x = p.de ? 12'(h) : 12'd0;
      p.y = p.de ? 12'(v) : 12'd0;
      cr = 0;
      cg = 0;
      cb = 0;
      case (md)
         0: ;
         2: cr = MX;
         3: cg = MX;
         4: cb = MX;
         5: begin
            c = (((h >> 4) & 1) ^ ((v >> 4) & 1)) ? 0 : MX;
            cr = c; cg = c; cb = c;
         end
         6: begin
            c = (((h >> 6) & 1) ^ ((v >> 6) & 1)) ? 0 : MX;
            cr = c; cg = c; cb = c;
         end
         7: begin
            c = (h / 4) % 64;
            cr = c; cg = c; cb = c;
         end
         8: begin
            c = (v / 4) % 64;
            cr = c; cg = c; cb = c;
         end
         9: begin
            idx = (h * 8) / HA;
            if (idx > 7) idx = 7;
            cr = (bars[idx] & 4) != 0 ? MX : 0;
            cg = (bars[idx] & 2) != 0 ? MX : 0;
            cb = (bars[idx] & 1) != 0 ? MX : 0;
         end
         10: begin
            c = (h == sc) ? MX : 0;
            cr = c; cg = c; cb = c;
         end
         default: begin
            cr = MX; cg = MX; cb = MX;
         end
      endcase
      if (p.de) begin
         p.r = CW'(cr);
         p.g = CW'(cg);
         p.b = CW'(cb);
      end
      p.m = 4'(md);
      p.fs = (h == 0) && (v == 0);
      return p;
   endfunction

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic tick();
      px_t e;
      px_t gt;
      int pos;
      int h;
      int v;
      int sc;
      bit req;
      @(posedge clk);
      #1;
      pos = 0;
      if (rst) begin
         e = '0;
         e.hs = 1'b1;
         e.vs = 1'b1;
         t = 0;
         mode_m = 0;
         pend = 1'b0;
         low_m = 0;
         fends = 0;
      end else begin
         pos = t % FRAME;
         h = pos % HT;
         v = pos / HT;
         sc = (t / FRAME) % HA;
         e = pix(h, v, mode_m, sc);
         for (int i = 0; i < NT; i++) begin
            if (tbl[i].md == mode_m && tbl[i].px == h && tbl[i].py == v) begin
               hit[i]++;
               chk($sformatf("tbl%0d_r", i), int'(r), tbl[i].er);
               chk($sformatf("tbl%0d_g", i), int'(g), tbl[i].eg);
               chk($sformatf("tbl%0d_b", i), int'(b), tbl[i].eb);
            end
         end
         req = 1'b0;
         if (!key_n) begin
            if (low_m == DB - 1) req = 1'b1;
            if (low_m < DB) low_m++;
         end else begin
            low_m = 0;
         end
         if (pos == FRAME - 1) begin
            fends++;
            if (fends % AF == 0) req = 1'b1;
            if (pend || req) mode_m = (mode_m == 10) ? 0 : mode_m + 1;
            pend = 1'b0;
         end else if (req) begin
            pend = 1'b1;
         end
         t++;
      end
      gt.hs = hs;
      gt.vs = vs;
      gt.de = de;
      gt.x = x;
      gt.y = y;
      gt.r = r;
      gt.g = g;
      gt.b = b;
      gt.m = mode;
      gt.fs = frame_start;
      checks++;
      if (gt !== e) begin
         errors++;
         $display("FAIL pixel pos=%0d got hs=%0b vs=%0b de=%0b x=%0d y=%0d r=%0d g=%0d b=%0d mode=%0d fs=%0b required hs=%0b vs=%0b de=%0b x=%0d y=%0d r=%0d g=%0d b=%0d mode=%0d fs=%0b",
            pos, gt.hs, gt.vs, gt.de, gt.x, gt.y, gt.r, gt.g, gt.b, gt.m, gt.fs,
            e.hs, e.vs, e.de, e.x, e.y, e.r, e.g, e.b, e.m, e.fs);
      end
   endtask

   task automatic rand_tick();
      if (burst > 0) begin
         key_n = 1'b0;
         burst--;
      end else begin
         key_n = 1'b1;
         if ($urandom_range(299) == 0) burst = int'($urandom_range(60, 5));
      end
      tick();
   endtask

   task automatic wait_pos(input int pos, input string nm);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2 * FRAME && !ok; i++) begin
         tick();
         if (t % FRAME == pos) ok = 1'b1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s timeout", nm);
      end
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_hs"}, hs, 1);
      chk({nm, "_vs"}, vs, 1);
      chk({nm, "_de"}, de, 0);
      chk({nm, "_x"}, x, 0);
      chk({nm, "_y"}, y, 0);
      chk({nm, "_rgb"}, {r, g, b}, 0);
      chk({nm, "_mode"}, mode, 0);
      chk({nm, "_fs"}, frame_start, 0);
   endtask

   initial begin
      int de_n;
      int hs_lo;
      int vs_lo;
      int per;
      int first_hs;
      bit done;

      tbl[0]  = '{0, 3, 2, 0, 0, 0};
      tbl[1]  = '{1, 5, 5, 63, 63, 63};
      tbl[2]  = '{2, 0, 0, 63, 0, 0};
      tbl[3]  = '{3, 31, 7, 0, 63, 0};
      tbl[4]  = '{4, 10, 3, 0, 0, 63};
      tbl[5]  = '{5, 16, 0, 0, 0, 0};
      tbl[6]  = '{5, 15, 0, 63, 63, 63};
      tbl[7]  = '{6, 20, 5, 63, 63, 63};
      tbl[8]  = '{7, 13, 1, 3, 3, 3};
      tbl[9]  = '{7, 31, 0, 7, 7, 7};
      tbl[10] = '{8, 0, 6, 1, 1, 1};
      tbl[11] = '{9, 0, 0, 63, 0, 0};
      tbl[12] = '{9, 3, 0, 63, 0, 0};
      tbl[13] = '{9, 4, 0, 0, 63, 0};
      tbl[14] = '{9, 8, 2, 0, 0, 63};
      tbl[15] = '{9, 12, 0, 63, 0, 63};
      tbl[16] = '{9, 16, 0, 63, 63, 0};
      tbl[17] = '{9, 20, 0, 0, 63, 63};
      tbl[18] = '{9, 24, 0, 63, 63, 63};
      tbl[19] = '{9, 31, 0, 0, 0, 0};
      for (int i = 0; i < NT; i++) hit[i] = 0;

      rst = 1'b1;
      key_n = 1'b1;
      repeat (3) tick();
      chk_reset("rst");

      rst = 1'b0;
      tick();
      chk("first_fs", frame_start, 1);
      chk("first_de", de, 1);
      chk("first_xy", {x, y}, 0);

      de_n = int'(de);
      hs_lo = int'(!hs);
      vs_lo = int'(!vs);
      per = 0;
      first_hs = -1;
      done = 1'b0;
      for (int i = 0; i < 2000 && !done; i++) begin
         tick();
         per++;
         if (frame_start) begin
            done = 1'b1;
         end else begin
            de_n += int'(de);
            hs_lo += int'(!hs);
            vs_lo += int'(!vs);
            if (!hs && first_hs < 0) first_hs = per;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL frame_period timeout");
      end
      chk("frame_period", per, 572);
      chk("de_per_frame", de_n, 256);
      chk("hs_low_per_frame", hs_lo, 52);
      chk("vs_low_per_frame", vs_lo, 88);
      chk("hs_low_offset", first_hs, 34);

      wait_pos(200, "btn_start");
      key_n = 1'b0;
      for (int i = 0; i < 700; i++) begin
         tick();
         if (t % FRAME == 1) begin
            chk("btn_mode_f2", mode, 1);
            chk("btn_fs_f2", frame_start, 1);
         end
      end
      key_n = 1'b1;
      wait_pos(360, "btn2_start");
      key_n = 1'b0;
      repeat (30) tick();
      key_n = 1'b1;
      wait_pos(1, "f3_start");
      chk("btn_auto_mode_f3", mode, 2);
      chk("btn_auto_fs_f3", frame_start, 1);

      done = 1'b0;
      for (int i = 0; i < 30000 && !done; i++) begin
         rand_tick();
         if (mode_m == 7) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL reach_mode7 timeout");
      end
      key_n = 1'b1;
      burst = 0;
      wait_pos(240, "mid_pos");
      chk("mid_mode", mode, 7);
      chk("mid_x", x, 19);
      chk("mid_y", y, 5);
      chk("mid_r", r, 4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset("midrst");
      tick();
      chk("midrst_fs", frame_start, 1);
      chk("midrst_de", de, 1);
      chk("midrst_xy", {x, y}, 0);
      chk("midrst_mode", mode, 0);

      for (int i = 0; i < 36 * FRAME; i++) rand_tick();

      for (int i = 0; i < NT; i++)
         chk($sformatf("tbl%0d_reached", i), int'(hit[i] > 0), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL expose parameters (name, default, meaning):
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch
- H_SYNC, 136, horizontal sync width
- H_BP, 160, horizontal back porch
- V_ACTIVE, 768, visible lines
- V_FP, 3, vertical front porch
- V_SYNC, 6, vertical sync width
- V_BP, 29, vertical back porch
- HS_POL, 0, asserted hs level
- VS_POL, 0, asserted vs level
- COLOR_W, 6, bits per colour channel
- DEBOUNCE, 90000, button-low cycles per step
- AUTO_FRAMES, 0, frames per automatic mode step; 0 = disabled

REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, pixel clock
- rst, in, 1, reset
- key_n, in, 1, mode-step button, active-low, already synchronised
- hs, out, 1, horizontal sync
- vs, out, 1, vertical sync
- de, out, 1, data enable
- x, out, 12, pixel column
- y, out, 12, pixel row
- r, out, COLOR_W, red
- g, out, COLOR_W, green
- b, out, COLOR_W, blue
- mode, out, 4, displayed pattern
- frame_start, out, 1, one-cycle pulse at pixel (0,0)

REQ-003 SHALL use one clock, clk; reset rst is synchronous and active-high.

Function
REQ-004 SHALL count h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of the four H params) and wrap to 0; v_cnt SHALL increment when h_cnt wraps, and wrap to 0 after V_TOTAL-1.
REQ-005 SHALL order each line/frame as active, front porch, sync, back porch; hs SHALL equal HS_POL for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else ~HS_POL; vs SHALL be defined the same way on v_cnt with VS_POL.
REQ-006 SHALL register all outputs with 1-cycle latency from counters; hs, vs, de, x, y, r, g, b and frame_start SHALL describe the same pixel in the same cycle.
REQ-007 de SHALL be 1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; x/y SHALL equal h_cnt/v_cnt when de=1 and hold 0 when de=0; r/g/b SHALL be 0 when de=0.
REQ-008 Patterns, with MAX = all-ones COLOR_W; mode values 11..15 are unreachable and SHALL render as 1:
- 0: black
- 1: white
- 2: red only (r=MAX)
- 3: green only
- 4: blue only
- 5: small grid, white when x[4]^y[4]=0, else black
- 6: large grid, as mode 5 using bit 6
- 7: horizontal grey ramp, all channels = (x>>2) mod 2^COLOR_W
- 8: vertical grey ramp, all channels = (y>>2) mod 2^COLOR_W
- 9: 8 colour bars, index = (x*8)/H_ACTIVE, colours in order red, green, blue, magenta, yellow, cyan, white, black
- 10: scrolling line, white where x==scroll, else black
REQ-009 scroll SHALL increment by 1 at each frame end (v_cnt and h_cnt at their maxima), wrapping from H_ACTIVE-1 to 0, in every mode.
REQ-010 Debounce: while key_n=1 the counter SHALL be 0; while key_n=0 it SHALL count and saturate at DEBOUNCE; exactly one step request SHALL be issued when it reaches DEBOUNCE. A new request requires key_n to return to 1.
REQ-011 Auto-step: if AUTO_FRAMES>0, a step request SHALL be issued every AUTO_FRAMES frame ends.
REQ-012 Step requests SHALL set a pending flag. mode SHALL advance by exactly 1 (10 wraps to 0) only at frame end, then clear pending. Multiple requests in one frame (button, auto, or both in the same cycle) SHALL yield a single advance.
REQ-013 frame_start SHALL be 1 for exactly one cycle per frame, coincident with x=0, y=0, de=1.

Reset
REQ-014 While rst=1 the block SHALL set:
- h_cnt, v_cnt, scroll, debounce counter, auto counter and pending to 0
- mode=0
- hs=~HS_POL, vs=~VS_POL
- de=0, x=0, y=0, r=g=b=0, frame_start=0
REQ-015 rst asserted mid-line or mid-frame SHALL take effect on the next clk edge. After release, the first frame_start SHALL occur 1 cycle after rst deasserts.

Verification
REQ-016 Default params, free-run 2 frames -> hs period 1344 cycles, low for 136 cycles starting 1048 cycles after line start; vs low for 6 lines; 786432 de=1 cycles per frame; frame_start period 1083264.
REQ-017 key_n held low 200000 cycles mid-frame (DEBOUNCE=90000) -> mode goes 0->1 exactly once, at the next frame end; no second step.
REQ-018 Mode 9, COLOR_W=6 -> x=0..127 gives r=63,g=0,b=0; x=128 gives g=63; x=896..1023 gives black.
REQ-019 AUTO_FRAMES=2 with a button step in the same frame as the auto step -> mode advances by 1, not 2; from mode 10 the next step gives 0.
REQ-020 Mode 10 -> line at x=0 in frame 0, x=1 in frame 1; after 1024 frames it is back at x=0.
REQ-021 rst pulsed for 1 cycle at h_cnt=500, v_cnt=300 in mode 7 -> next cycle all outputs at REQ-014 values; mode=0; timing restarts from pixel (0,0).
